// File: rtl/replica_pkg.sv
// Shared types for the replica array readout path.
//   replica_data_t  : one ordering word from a chain tail
//   total_data_t    : one distance word from a chain tail
//   readout_state_t : sweep state of chain_readout_mux
//   cnt_width()     : counter width for a modulus, never below one bit
package replica_pkg;

  localparam int unsigned replica_data_w = 16;
  localparam int unsigned total_data_w   = 32;

  typedef logic [replica_data_w-1:0] replica_data_t;
  typedef logic [total_data_w-1:0]   total_data_t;

  localparam int unsigned ord_beats_default = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } readout_state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chain_readout_mux_wrap_counter.sv
// wrap_counter: modulo counter with synchronous clear, used for the readout
// beat/chain/replica counters and the distance select.
//   clk, reset : clock, synchronous active-high reset (loads reset_value)
//   inc        : advance one step (up, or down when down=1)
//   clear      : synchronous return to reset_value, wins over inc
//   value      : current count
//   wrap       : high in the cycle an inc moves the count past its last value
//                (modulus-1 counting up, 0 counting down); feeds the next
//                counter's inc when cascaded
module wrap_counter
  import replica_pkg::*;
#(
  parameter int unsigned modulus     = 2,
  parameter int unsigned reset_value = 0,
  parameter bit          down        = 1'b0,
  parameter int unsigned width       = cnt_width(modulus)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [width-1:0] value,
  output logic             wrap
);

  localparam logic [width-1:0] top_val  = width'(modulus - 1);
  localparam logic [width-1:0] last_val = down ? '0 : top_val;
  localparam logic [width-1:0] rst_val  = width'(reset_value);
  localparam logic [width-1:0] one_val  = width'(1);

  logic [width-1:0] value_q;
  logic [width-1:0] value_d;

  always_comb begin
    wrap    = inc && !clear && (value_q == last_val);
    value_d = value_q;
    if (clear) begin
      value_d = rst_val;
    end else if (inc) begin
      // A modulus of 1 makes last_val 0, so the count is pinned at 0 and
      // every inc wraps straight through to the next stage.
      if (wrap) value_d = down ? top_val : '0;
      else      value_d = down ? (value_q - one_val) : (value_q + one_val);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) value_q <= rst_val;
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/chain_readout_mux.sv
// chain_readout_mux: sequences host readout across the chain tails of the
// replica array and multiplexes ordering and distance words onto the bus path.
//   clk, reset          : clock, synchronous active-high reset
//   rd_clear            : synchronous sweep restart (also clears rd_err)
//   ordering_read       : one ordering beat consumed
//   chain_ord_valid/data: per-chain tail ordering valid and data
//   ordering_out_valid/data : selected chain (combinational or registered)
//   distance_shift      : one distance word consumed
//   chain_dis_data      : per-chain tail distance
//   distance_rdata      : selected distance (combinational on dsel)
//   rd_chain            : current ordering chain index
//   rd_done             : one-cycle pulse after the last read of a sweep
//   rd_err              : sticky, read taken while the selected chain was invalid
//   dbg_state/beat/rep/dsel_wrap : internal state for observation
//
// Handshake: ordering_read and distance_shift are consume strobes with no
// back-pressure. Any cycle with the strobe high and rd_clear low is one
// accepted event; the strobes are independent of each other, and rd_clear in
// the same cycle drops them.
module chain_readout_mux
  import replica_pkg::*;
#(
  parameter int unsigned replica_num = 32,
  parameter int unsigned chain_num   = 2,
  parameter int unsigned ord_beats   = ord_beats_default,
  parameter bit          out_reg     = 1'b0,
  localparam int unsigned chain_w    = cnt_width(chain_num),
  localparam int unsigned beat_w     = cnt_width(ord_beats),
  localparam int unsigned rep_w      = cnt_width(replica_num)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_clear,
  input  logic                 ordering_read,
  input  logic [chain_num-1:0] chain_ord_valid,
  input  replica_data_t        chain_ord_data [chain_num],
  output logic                 ordering_out_valid,
  output replica_data_t        ordering_out_data,
  input  logic                 distance_shift,
  input  total_data_t          chain_dis_data [chain_num],
  output total_data_t          distance_rdata,
  output logic [chain_w-1:0]   rd_chain,
  output logic                 rd_done,
  output logic                 rd_err,
  output readout_state_t       dbg_state,
  output logic [beat_w-1:0]    dbg_beat,
  output logic [rep_w-1:0]     dbg_rep,
  output logic                 dbg_dsel_wrap
);

  logic               read_acc;
  logic               shift_acc;
  logic               beat_wrap;
  logic               chain_wrap;
  logic               sweep_end;
  logic [chain_w-1:0] chain_idx;
  logic [chain_w-1:0] dsel_idx;
  logic               sel_valid;
  replica_data_t      sel_data;

  assign read_acc  = ordering_read  && !rd_clear;
  assign shift_acc = distance_shift && !rd_clear;

  // beat -> chain -> rep cascade; the rep wrap marks the last read of a sweep.
  wrap_counter #(.modulus(ord_beats), .reset_value(0), .down(1'b0), .width(beat_w)) u_beat (
    .clk(clk), .reset(reset), .inc(read_acc), .clear(rd_clear),
    .value(dbg_beat), .wrap(beat_wrap)
  );

  wrap_counter #(.modulus(chain_num), .reset_value(0), .down(1'b0), .width(chain_w)) u_chain (
    .clk(clk), .reset(reset), .inc(beat_wrap), .clear(rd_clear),
    .value(chain_idx), .wrap(chain_wrap)
  );

  wrap_counter #(.modulus(replica_num), .reset_value(0), .down(1'b0), .width(rep_w)) u_rep (
    .clk(clk), .reset(reset), .inc(chain_wrap), .clear(rd_clear),
    .value(dbg_rep), .wrap(sweep_end)
  );

  // Distance words come out highest chain first (tw before or for two chains).
  wrap_counter #(.modulus(chain_num), .reset_value(chain_num - 1), .down(1'b1), .width(chain_w)) u_dsel (
    .clk(clk), .reset(reset), .inc(shift_acc), .clear(rd_clear),
    .value(dsel_idx), .wrap(dbg_dsel_wrap)
  );

  // Sweep FSM: state register / next state / outputs.
  readout_state_t state_q;
  readout_state_t state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rd_clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (read_acc) state_d = sweep_end ? DONE : ACTIVE;
        ACTIVE:  if (sweep_end) state_d = DONE;
        // A read arriving in DONE opens the next sweep without an IDLE gap.
        DONE:    state_d = read_acc ? (sweep_end ? DONE : ACTIVE) : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rd_done   = (state_q == DONE);
    dbg_state = state_q;
  end

  // Sticky underflow flag.
  logic err_q;
  logic err_d;

  always_comb begin
    err_d = err_q;
    if (rd_clear)                    err_d = 1'b0;
    else if (read_acc && !sel_valid) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign rd_err   = err_q;
  assign rd_chain = chain_idx;

  // Muxes on the registered selects.
  assign sel_valid      = chain_ord_valid[chain_idx];
  assign sel_data       = chain_ord_data[chain_idx];
  assign distance_rdata = chain_dis_data[dsel_idx];

  generate
    if (out_reg) begin : g_out_reg
      logic          out_valid_q;
      logic          out_valid_d;
      replica_data_t out_data_q;
      replica_data_t out_data_d;

      always_comb begin
        out_valid_d = sel_valid;
        out_data_d  = sel_data;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
        end else begin
          out_valid_q <= out_valid_d;
          out_data_q  <= out_data_d;
        end
      end

      assign ordering_out_valid = out_valid_q;
      assign ordering_out_data  = out_data_q;
    end else begin : g_out_comb
      assign ordering_out_valid = sel_valid;
      assign ordering_out_data  = sel_data;
    end
  endgenerate

endmodule
